// File: rtl/rv32_writeback_arbiter.sv
// Round-robin writeback arbiter that feeds the single register-file write port,
// plus the 32-entry pending-write scoreboard that decode uses for hazard checks.
module rv32_writeback_arbiter #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0][4:0]  req_rd,
    input  logic [NUM_REQ-1:0][31:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rf_write,
    output logic [4:0]               rf_rw,
    output logic [31:0]              rf_d,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    input  logic [4:0]               query_r1,
    input  logic [4:0]               query_r2,
    input  logic                     query_use_r1,
    input  logic                     query_use_r2,
    input  logic [4:0]               query_rd,
    input  logic                     query_use_rd,
    output logic                     hazard_stall,
    output logic [31:0]              busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic [PW-1:0] ptr_next;
    logic          xfer;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;
    logic [31:0]   busy_next;
    int unsigned   idx;

    // Search starts at the pointer and wraps; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        gidx      = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr) + k) % NUM_REQ;
            if (!xfer && req_valid[idx[PW-1:0]]) begin
                xfer = 1'b1;
                gidx = idx[PW-1:0];
            end
        end
        if (!resetn) begin
            xfer = 1'b0;
        end
        if (xfer) begin
            req_ready[gidx] = 1'b1;
        end
    end

    assign sel_rd   = req_rd[gidx];
    assign sel_data = req_data[gidx];
    assign ptr_next = PW'((32'(gidx) + 1) % NUM_REQ);

    // Clear on acceptance first, then set, so a new producer wins a same-cycle collision.
    always_comb begin
        busy_next = busy;
        if (xfer) begin
            busy_next[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign hazard_stall = resetn &&
                          ((query_use_r1 && busy[query_r1]) ||
                           (query_use_r2 && busy[query_r2]) ||
                           (query_use_rd && busy[query_rd]));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr      <= '0;
            rf_write <= 1'b0;
            rf_rw    <= '0;
            rf_d     <= '0;
            busy     <= '0;
        end else begin
            if (xfer) begin
                ptr <= ptr_next;
            end
            // x0 transfers are consumed but never reach the register file.
            rf_write <= xfer && (sel_rd != '0);
            if (xfer && (sel_rd != '0)) begin
                rf_rw <= sel_rd;
                rf_d  <= sel_data;
            end
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_rv32_writeback_arbiter.sv
// Directed scenarios followed by randomized traffic, each cycle checked against
// a transaction-level model of grants, the write port and the scoreboard.
module tb_rv32_writeback_arbiter;

    localparam int N = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [N-1:0]      valid = '0;
    logic [N-1:0][4:0] rd = '0;
    logic [N-1:0][31:0] data = '0;
    logic [N-1:0]      ready;
    logic              rf_write;
    logic [4:0]        rf_rw;
    logic [31:0]       rf_d;
    logic              issue_valid = 1'b0;
    logic [4:0]        issue_rd = '0;
    logic [4:0]        query_r1 = '0;
    logic [4:0]        query_r2 = '0;
    logic              query_use_r1 = 1'b0;
    logic              query_use_r2 = 1'b0;
    logic [4:0]        query_rd = '0;
    logic              query_use_rd = 1'b0;
    logic              hazard_stall;
    logic [31:0]       busy;

    rv32_writeback_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(valid), .req_rd(rd), .req_data(data), .req_ready(ready),
        .rf_write(rf_write), .rf_rw(rf_rw), .rf_d(rf_d),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .query_r1(query_r1), .query_r2(query_r2),
        .query_use_r1(query_use_r1), .query_use_r2(query_use_r2),
        .query_rd(query_rd), .query_use_rd(query_use_rd),
        .hazard_stall(hazard_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr = 0;
    bit [31:0]   m_busy = '0;
    bit          m_write = 1'b0;
    bit [4:0]    m_rw = '0;
    bit [31:0]   m_d = '0;
    int          cur_g = -1;
    int          grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_stall();
        return (query_use_r1 && m_busy[query_r1]) ||
               (query_use_r2 && m_busy[query_r2]) ||
               (query_use_rd && m_busy[query_rd]);
    endfunction

    // Mid-cycle: combinational outputs against the model.
    task automatic comb_phase();
        logic [N-1:0] exp_ready;
        #2;
        cur_g = -1;
        for (int k = 0; k < N; k++) begin
            if (cur_g < 0 && valid[(m_ptr + k) % N]) cur_g = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (cur_g >= 0) exp_ready[cur_g] = 1'b1;
        chk("req_ready", 32'(ready), 32'(exp_ready));
        chk("hazard_stall", 32'(hazard_stall), 32'(model_stall()));
        chk("illegal_issue", 32'(issue_valid && hazard_stall), 32'd0);
    endtask

    // Just after the edge: advance the model and check registered outputs.
    task automatic seq_phase();
        logic [4:0] g_rd;
        @(posedge clk);
        #1;
        m_write = 1'b0;
        if (cur_g >= 0) begin
            g_rd = rd[cur_g];
            grants.push_back(cur_g);
            if (g_rd != 0) begin
                m_write = 1'b1;
                m_rw    = g_rd;
                m_d     = data[cur_g];
            end
            m_busy[g_rd] = 1'b0;
            m_ptr = (cur_g + 1) % N;
            valid[cur_g] = 1'b0;
        end
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        chk("rf_write", 32'(rf_write), 32'(m_write));
        if (m_write) begin
            chk("rf_rw", 32'(rf_rw), 32'(m_rw));
            chk("rf_d", rf_d, m_d);
        end
        chk("busy", busy, m_busy);
    endtask

    task automatic step();
        comb_phase();
        seq_phase();
    endtask

    task automatic clear_inputs();
        valid = '0;
        issue_valid = 1'b0;
        query_use_r1 = 1'b0;
        query_use_r2 = 1'b0;
        query_use_rd = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_busy = '0;
        m_write = 1'b0;
        m_rw = '0;
        m_d = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_write"}, 32'(rf_write), 32'd0);
        chk({tag, "_rf_rw"}, 32'(rf_rw), 32'd0);
        chk({tag, "_rf_d"}, rf_d, 32'd0);
        chk({tag, "_busy"}, busy, 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd0);
        chk({tag, "_stall"}, 32'(hazard_stall), 32'd0);
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic void issue(input logic [4:0] r);
        issue_valid  = 1'b1;
        issue_rd     = r;
        query_rd     = r;
        query_use_rd = 1'b1;
    endfunction

    initial begin
        // Reset with requesters (illegally) valid: ready must still be gated off.
        valid = '1;
        query_use_r1 = 1'b1;
        #2;
        chk("reset_ready_gated", 32'(ready), 32'd0);
        do_reset();

        // 1: single request
        valid[0] = 1'b1; rd[0] = 5'd5; data[0] = 32'hDEADBEEF;
        comb_phase();
        chk("t1_ready", 32'(ready), 32'b001);
        seq_phase();
        chk("t1_rf_write", 32'(rf_write), 32'd1);
        chk("t1_rf_rw", 32'(rf_rw), 32'd5);
        chk("t1_rf_d", rf_d, 32'hDEADBEEF);
        step();
        chk("t1_rf_write_off", 32'(rf_write), 32'd0);

        // 2: all requesters continuously valid -> strict rotation from 0
        do_reset();
        grants.delete();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i]) begin
                    valid[i] = 1'b1;
                    rd[i] = 5'(10 + i);
                    data[i] = 32'h1000 * (c + 1) + i;
                end
            end
            step();
            chk("t2_rf_rw_owner", 32'(rf_rw), 32'(10 + c % N));
        end
        for (int c = 0; c < 6; c++) begin
            chk("t2_grant_order", grants[c], c % N);
        end
        valid = '0;

        // 3: RAW hazard on x7, cleared by its writeback
        issue(5'd7);
        step();
        issue_valid = 1'b0; query_use_rd = 1'b0;
        query_r1 = 5'd7; query_use_r1 = 1'b1;
        valid[1] = 1'b1; rd[1] = 5'd7; data[1] = 32'h77;
        comb_phase();
        chk("t3_stall_set", 32'(hazard_stall), 32'd1);
        seq_phase();
        comb_phase();
        chk("t3_stall_clear", 32'(hazard_stall), 32'd0);
        chk("t3_busy7", 32'(busy[7]), 32'd0);
        seq_phase();
        clear_inputs();

        // 4: same-cycle set and clear of x9
        valid[2] = 1'b1; rd[2] = 5'd9; data[2] = 32'h99;
        issue(5'd9);
        step();
        chk("t4_busy9", 32'(busy[9]), 32'd1);
        clear_inputs();

        // 5: x0 issue and x0 writeback
        valid[0] = 1'b1; rd[0] = 5'd0; data[0] = 32'h55;
        issue(5'd0);
        comb_phase();
        chk("t5_ready0", 32'(ready[0]), 32'd1);
        seq_phase();
        chk("t5_busy0", 32'(busy[0]), 32'd0);
        chk("t5_no_write", 32'(rf_write), 32'd0);
        clear_inputs();

        // 6: asynchronous reset between edges
        do_reset();
        issue(5'd7);
        step();
        issue(5'd11);
        valid[0] = 1'b1; rd[0] = 5'd3; data[0] = 32'h33;
        step();
        chk("t6_busy_pre", busy, 32'h0000_0880);
        chk("t6_write_pre", 32'(rf_write), 32'd1);
        clear_inputs();
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("t6_async");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            valid[i] = 1'b1; rd[i] = 5'(20 + i); data[i] = 32'hA0 + i;
        end
        comb_phase();
        chk("t6_first_grant", 32'(ready), 32'b001);
        seq_phase();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!valid[i] && $urandom_range(0, 2) != 0) begin
                    valid[i] = 1'b1;
                    rd[i]    = 5'($urandom_range(0, 15));
                    data[i]  = $urandom;
                end
            end
            query_r1     = 5'($urandom_range(0, 15));
            query_r2     = 5'($urandom_range(0, 15));
            query_rd     = 5'($urandom_range(0, 15));
            query_use_r1 = 1'($urandom_range(0, 1));
            query_use_r2 = 1'($urandom_range(0, 1));
            query_use_rd = 1'($urandom_range(0, 1));
            issue_rd     = query_rd;
            issue_valid  = query_use_rd && !model_stall() && ($urandom_range(0, 1) == 1);
            step();
        end
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32_writeback_arbiter.md
Name: rv32_writeback_arbiter

Overview:
Shares the single write port of the core register file between several writeback sources (ALU, load unit, multi-cycle mul/div). It uses a round-robin valid/ready arbiter and a one-stage registered write port. A 32-entry pending-write scoreboard tells decode whether a source or destination register still has an outstanding producer. It sits between the execute/memory units and the register file write inputs (write, rw, d).

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8); requester 0 has first priority after reset.

Ports:
clk  in  1  core clock; all state updates on posedge
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  requester i holds a writeback
req_rd  in  NUM_REQ x 5 (rv_reg_id_t)  destination register per requester
req_data  in  NUM_REQ x 32 (rv32_word)  writeback data per requester
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] && req_ready[i]
rf_write  out  1  register file write enable
rf_rw  out  5  register file write index
rf_d  out  32  register file write data
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  5  destination of the issuing instruction
query_r1  in  5  decode source 1
query_r2  in  5  decode source 2
query_use_r1  in  1  source 1 is actually read
query_use_r2  in  1  source 2 is actually read
query_rd  in  5  destination of the instruction in decode
query_use_rd  in  1  the instruction writes query_rd
hazard_stall  out  1  decode must not issue this cycle
busy  out  32  scoreboard bit vector (debug/verification)

Behaviour:
- Reset (resetn low, async): rf_write=0, rf_rw=0, rf_d=0, busy=0, round-robin pointer=0. While in reset, req_ready=0 and hazard_stall=0.
- Arbitration is combinational each cycle.
  - Search starts at pointer p and wraps modulo NUM_REQ. The first i with req_valid[i] gets req_ready[i]=1; all others get 0.
  - No valid requester: req_ready all 0 and p unchanged.
  - On a grant to i, p <= (i+1) mod NUM_REQ at posedge.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.
- Requester rules: once asserted, req_valid, req_rd and req_data must stay stable until the transfer. A requester never drops valid without a transfer.
- Write port, latency 1 cycle.
  - On a transfer at posedge N: rf_write=1, rf_rw=req_rd[i], rf_d=req_data[i] during cycle N+1. The register file captures them at the negedge inside cycle N+1.
  - No transfer: rf_write=0 next cycle; rf_rw and rf_d hold their previous values.
- x0 writes: a transfer with rd=0 is accepted (ready given) but produces rf_write=0.
- Scoreboard:
  - busy[r] is set at posedge when issue_valid && issue_rd==r && r!=0.
  - busy[r] is cleared at posedge when a transfer with rd==r is accepted. It clears at acceptance, not when rf_write is driven.
  - Set and clear of the same r in the same cycle: set wins (new producer).
  - busy[0] is constantly 0.
- hazard_stall (combinational), asserted if any of these holds:
  - query_use_r1 && busy[query_r1]
  - query_use_r2 && busy[query_r2]
  - query_use_rd && busy[query_rd] (WAW; guarantees at most one outstanding producer per register)
- Forwarding gap: a register being written by rf_write in the current cycle is already not busy. Decode reads it after the negedge write, so no extra stall is required.
- Contract: decode asserts issue_valid only when hazard_stall=0 for that instruction. An issue while hazard_stall=1 is illegal; the bench flags it with an assertion.
- Mid-operation reset: all pending grants, busy bits and the pointer are discarded immediately. Requesters must drop req_valid during reset.

Test Plan:
1. Reset then a single request: req_valid=001, rd=5, data=0xDEADBEEF -> req_ready=001 same cycle; next cycle rf_write=1, rf_rw=5, rf_d=0xDEADBEEF; following cycle rf_write=0.
2. All three requesters held valid for 6 cycles -> grants 0,1,2,0,1,2. Each requester receives exactly 2 grants; rf_rw sequence matches its rd.
3. Scoreboard RAW: issue rd=7; next cycle query_r1=7, use_r1=1 -> hazard_stall=1. After the transfer with rd=7 is accepted, the next cycle gives hazard_stall=0 and busy[7]=0.
4. Same-cycle set/clear: a transfer with rd=9 is accepted while issue_valid with issue_rd=9 -> busy[9]=1 afterwards.
5. x0 handling: issue rd=0 -> busy stays 0. A transfer with rd=0 gets ready=1, and rf_write stays 0 the next cycle.
6. Async reset mid-stream: resetn low between clock edges while busy=0x0000_0880 and rf_write=1 -> busy=0 and rf_write=0 immediately, without waiting for an edge. After release the first grant goes to requester 0.
